// File: rtl/lfsr_pkg.sv
// Shared LFSR types, common tap masks and the single Galois step used by the unroller.
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_W = 64;

    typedef enum logic [0:0] {
        LFSR_IDLE = 1'b0,
        LFSR_RUN  = 1'b1
    } lfsr_fsm_e;

    localparam logic [31:0] LFSR_POLY_32 = 32'h8020_0003;
    localparam logic [15:0] LFSR_POLY_16 = 16'hB400;
    localparam logic [7:0]  LFSR_POLY_8  = 8'hB8;

    // One right-shifting Galois step on the low `width` bits; bits at or above width stay zero.
    function automatic logic [LFSR_MAX_W-1:0] galois_step(
        input logic [LFSR_MAX_W-1:0] q,
        input logic [LFSR_MAX_W-1:0] poly,
        input int                    width
    );
        logic [LFSR_MAX_W-1:0] n;
        logic [LFSR_MAX_W-1:0] qs;
        n  = '0;
        qs = q >> 1;
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            if (i == width - 1) begin
                n[i] = q[0];
            end else if (i < width - 1) begin
                n[i] = qs[i] ^ (poly[i] & q[0]);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr_galois_step.sv
// Combinational OUT_WIDTH-step unroll of the Galois LFSR.
// bits_o[k] is the bit shifted out by step k; state_o is the state after all steps.
module lfsr_galois_step
    import lfsr_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] POLY       = DATA_WIDTH'(LFSR_POLY_32),
    parameter int unsigned           OUT_WIDTH  = 8
) (
    input  logic [DATA_WIDTH-1:0] state_i,
    output logic [OUT_WIDTH-1:0]  bits_o,
    output logic [DATA_WIDTH-1:0] state_o
);

    localparam logic [LFSR_MAX_W-1:0] POLY_EXT = LFSR_MAX_W'(POLY);

    always_comb begin
        logic [LFSR_MAX_W-1:0] q;
        q                   = '0;
        q[DATA_WIDTH-1:0]   = state_i;
        bits_o              = '0;
        for (int k = 0; k < int'(OUT_WIDTH); k++) begin
            bits_o[k] = q[0];
            q         = galois_step(q, POLY_EXT, int'(DATA_WIDTH));
        end
        state_o = q[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/lfsr_prbs_gen.sv
// PRBS beat generator: Galois LFSR unrolled OUT_WIDTH bits per beat behind a valid/ready output.
// Latency 1 from en_i in IDLE; beat and state held while ready_i is low; wr_i reseeds and drops any pending beat.
module lfsr_prbs_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] POLY       = DATA_WIDTH'(LFSR_POLY_32),
    parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(32'h0000_0001),
    parameter int unsigned           OUT_WIDTH  = 8,
    parameter int unsigned           CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [OUT_WIDTH-1:0]  dat_o,
    output logic [DATA_WIDTH-1:0] state_o,
    output logic                  lockup_o,
    output logic [CNT_WIDTH-1:0]  cnt_o
);

    if (DATA_WIDTH < 2 || DATA_WIDTH > LFSR_MAX_W) begin : g_bad_width
        $fatal(1, "lfsr_prbs_gen: DATA_WIDTH out of range");
    end
    if (OUT_WIDTH < 1 || OUT_WIDTH > DATA_WIDTH) begin : g_bad_out_width
        $fatal(1, "lfsr_prbs_gen: OUT_WIDTH out of range");
    end
    if (SEED == '0) begin : g_bad_seed
        $fatal(1, "lfsr_prbs_gen: SEED must be non-zero");
    end

    lfsr_fsm_e             fsm_q, fsm_d;
    logic [DATA_WIDTH-1:0] state_q, state_d;
    logic [OUT_WIDTH-1:0]  dat_q, dat_d;
    logic                  lock_q, lock_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [OUT_WIDTH-1:0]  beat_bits;
    logic [DATA_WIDTH-1:0] beat_state;

    lfsr_galois_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .POLY       (POLY),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_step (
        .state_i (state_q),
        .bits_o  (beat_bits),
        .state_o (beat_state)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        dat_d   = dat_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        if (wr_i) begin
            // An all-zero seed would freeze the LFSR, so substitute SEED and flag it.
            if (dat_i == '0) begin
                state_d = SEED;
                lock_d  = 1'b1;
            end else begin
                state_d = dat_i;
                lock_d  = 1'b0;
            end
            dat_d = '0;
            cnt_d = '0;
            fsm_d = LFSR_IDLE;
        end else begin
            case (fsm_q)
                LFSR_IDLE: begin
                    if (en_i) begin
                        dat_d   = beat_bits;
                        state_d = beat_state;
                        fsm_d   = LFSR_RUN;
                    end
                end
                LFSR_RUN: begin
                    if (ready_i) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                        if (en_i) begin
                            dat_d   = beat_bits;
                            state_d = beat_state;
                        end else begin
                            fsm_d = LFSR_IDLE;
                        end
                    end
                end
                default: fsm_d = LFSR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q   <= LFSR_IDLE;
            state_q <= SEED;
            dat_q   <= '0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            dat_q   <= dat_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o  = (fsm_q == LFSR_RUN);
    assign dat_o    = dat_q;
    assign state_o  = state_q;
    assign lockup_o = lock_q;
    assign cnt_o    = cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Directed bench for lfsr_prbs_gen: 4-bit configs with hand-derived beats, plus a 32-bit run against a model.
module tb_lfsr_prbs_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-bit, 4 bits per beat
    logic       rst4 = 1'b1, en4 = 1'b0, wr4 = 1'b0, rdy4 = 1'b0;
    logic [3:0] din4 = '0;
    logic       v4, l4;
    logic [3:0] d4, s4;
    logic [7:0] c4;

    // 4-bit, 1 bit per beat
    logic       rst1 = 1'b1, en1 = 1'b0, wr1 = 1'b0, rdy1 = 1'b0;
    logic [3:0] din1 = '0;
    logic       v1, l1;
    logic [0:0] d1;
    logic [3:0] s1;
    logic [7:0] c1;

    // default 32-bit config
    logic        rst32 = 1'b1, en32 = 1'b0, wr32 = 1'b0, rdy32 = 1'b0;
    logic [31:0] din32 = '0;
    logic        v32, l32;
    logic [7:0]  d32;
    logic [31:0] s32, c32;

    lfsr_prbs_gen #(.DATA_WIDTH(4), .POLY(4'h1), .SEED(4'h1), .OUT_WIDTH(4), .CNT_WIDTH(8)) u4 (
        .clk_i(clk), .rst_i(rst4), .en_i(en4), .wr_i(wr4), .dat_i(din4), .valid_o(v4),
        .ready_i(rdy4), .dat_o(d4), .state_o(s4), .lockup_o(l4), .cnt_o(c4)
    );

    lfsr_prbs_gen #(.DATA_WIDTH(4), .POLY(4'h1), .SEED(4'h1), .OUT_WIDTH(1), .CNT_WIDTH(8)) u1 (
        .clk_i(clk), .rst_i(rst1), .en_i(en1), .wr_i(wr1), .dat_i(din1), .valid_o(v1),
        .ready_i(rdy1), .dat_o(d1), .state_o(s1), .lockup_o(l1), .cnt_o(c1)
    );

    lfsr_prbs_gen u32 (
        .clk_i(clk), .rst_i(rst32), .en_i(en32), .wr_i(wr32), .dat_i(din32), .valid_o(v32),
        .ready_i(rdy32), .dat_o(d32), .state_o(s32), .lockup_o(l32), .cnt_o(c32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset4();
        rst4 = 1'b1; en4 = 1'b0; wr4 = 1'b0; rdy4 = 1'b0; din4 = '0;
        tick();
        rst4 = 1'b0;
    endtask

    localparam logic [31:0] MASK32 = 32'h8020_0003 | 32'h8000_0000;

    function automatic logic [31:0] mstep(input logic [31:0] q);
        return (q >> 1) ^ (q[0] ? MASK32 : 32'h0);
    endfunction

    logic [3:0]  exp_d [4];
    logic [3:0]  exp_s [4];
    logic        seq15 [15];
    logic [31:0] mq, mt;
    logic [7:0]  eb;
    int          beats, cyc;

    initial begin
        exp_d = '{4'hF, 4'hA, 4'h9, 4'h8};
        exp_s = '{4'hE, 4'hB, 4'h8, 4'h9};
        seq15 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // reset state
        tick(); tick();
        check("rst_valid", v4, 1'b0);
        check("rst_dat", d4, 4'h0);
        check("rst_state", s4, 4'h1);
        check("rst_lockup", l4, 1'b0);
        check("rst_cnt", c4, 8'h0);

        // back-to-back beats
        rst4 = 1'b0; en4 = 1'b1; rdy4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("b2b_valid%0d", i), v4, 1'b1);
            check($sformatf("b2b_dat%0d", i), d4, exp_d[i]);
            check($sformatf("b2b_state%0d", i), s4, exp_s[i]);
            check($sformatf("b2b_cnt%0d", i), c4, 8'(i));
        end
        tick();
        check("b2b_cnt_final", c4, 8'd4);

        // 1-bit beats cover the full period
        rst1 = 1'b0; en1 = 1'b1; rdy1 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("seq_bit%0d", i), d1, seq15[i]);
            if (i == 0) check("seq_state_first", s1, 4'h9);
        end
        check("seq_state_period", s1, 4'h1);
        check("seq_cnt", c1, 8'd14);

        // back-pressure holds the beat
        reset4();
        en4 = 1'b1; rdy4 = 1'b0;
        tick();
        check("bp_first", d4, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold_dat%0d", i), d4, 4'hF);
            check($sformatf("bp_hold_valid%0d", i), v4, 1'b1);
            check($sformatf("bp_hold_cnt%0d", i), c4, 8'd0);
            check($sformatf("bp_hold_state%0d", i), s4, 4'hE);
        end
        rdy4 = 1'b1;
        tick();
        check("bp_release_dat", d4, 4'hA);
        check("bp_release_cnt", c4, 8'd1);

        // zero seed load drops the pending beat
        reset4();
        en4 = 1'b1; rdy4 = 1'b1;
        tick();
        check("wr0_pre_valid", v4, 1'b1);
        wr4 = 1'b1; din4 = 4'h0;
        tick();
        wr4 = 1'b0;
        check("wr0_valid", v4, 1'b0);
        check("wr0_cnt", c4, 8'd0);
        check("wr0_lockup", l4, 1'b1);
        check("wr0_state", s4, 4'h1);
        check("wr0_dat", d4, 4'h0);
        tick();
        check("wr0_resume_dat", d4, 4'hF);
        check("wr0_resume_cnt", c4, 8'd0);
        check("wr0_resume_lockup", l4, 1'b1);
        wr4 = 1'b1; din4 = 4'hE;
        tick();
        wr4 = 1'b0;
        check("wrE_lockup", l4, 1'b0);
        check("wrE_valid", v4, 1'b0);
        check("wrE_state", s4, 4'hE);
        tick();
        check("wrE_dat", d4, 4'hA);
        check("wrE_next_state", s4, 4'hB);

        // en dropped during a stall still delivers the beat
        reset4();
        en4 = 1'b1; rdy4 = 1'b0;
        tick();
        en4 = 1'b0;
        tick();
        check("endrop_valid_held", v4, 1'b1);
        check("endrop_dat_held", d4, 4'hF);
        rdy4 = 1'b1;
        tick();
        check("endrop_valid_off", v4, 1'b0);
        check("endrop_cnt", c4, 8'd1);
        check("endrop_state", s4, 4'hE);
        tick();
        check("endrop_idle_state", s4, 4'hE);
        check("endrop_idle_valid", v4, 1'b0);

        // reset mid-stream clears lockup and counters
        reset4();
        wr4 = 1'b1; din4 = 4'h0;
        tick();
        wr4 = 1'b0; en4 = 1'b1; rdy4 = 1'b1;
        tick(); tick(); tick();
        check("midrst_pre_dat", d4, 4'h9);
        check("midrst_pre_lockup", l4, 1'b1);
        rst4 = 1'b1;
        tick();
        check("midrst_valid", v4, 1'b0);
        check("midrst_cnt", c4, 8'd0);
        check("midrst_state", s4, 4'h1);
        check("midrst_lockup", l4, 1'b0);
        check("midrst_dat", d4, 4'h0);
        rst4 = 1'b0; en4 = 1'b0;

        // 32-bit default run against the model with random ready
        rst32 = 1'b1;
        tick();
        rst32 = 1'b0; en32 = 1'b1;
        mq = 32'h1; beats = 0; cyc = 0;
        while (beats < 1000 && cyc < 5000) begin
            rdy32 = 1'($urandom_range(0, 1));
            if (v32) begin
                mt = mq;
                eb = '0;
                for (int k = 0; k < 8; k++) begin
                    eb[k] = mt[0];
                    mt    = mstep(mt);
                end
                check("prbs32_dat", d32, eb);
                check("prbs32_state", s32, mt);
                check("prbs32_nonzero", (s32 != 32'h0), 1'b1);
                if (rdy32) begin
                    mq = mt;
                    beats++;
                end
            end
            tick();
            cyc++;
        end
        check("prbs32_budget", beats, 1000);
        check("prbs32_cnt", c32, 32'd1000);
        en32 = 1'b0; rdy32 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
